speaker_vote_accum: RTL and testbench

SPEAKER_VOTE_ACCUM -- requirements
Module: speaker_vote_accum

---
 rtl/spk_vote_pkg.sv | 31 +++
 rtl/spk_argmax4.sv | 40 ++++
 rtl/speaker_vote_accum.sv | 167 ++++++++++++++++
 tb/tb_speaker_vote_accum.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spk_vote_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spk_vote_pkg
// Description : Shared types and constants for the speaker vote accumulator.
//               This package holds the FSM state enum, the speaker count, the
//               vote-count width, the "unknown speaker" code and a one-hot
//               helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package spk_vote_pkg;

  localparam int NUM_SPK = 4;
  localparam int VOTE_W  = 4;

  // The result code used when no speaker can be declared.
  localparam logic [NUM_SPK-1:0] SPK_UNKNOWN = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_DONE    = 2'd3
  } vote_state_t;

  // Returns 1 when exactly one bit of the identification vector is set.
  function automatic logic is_onehot(input logic [NUM_SPK-1:0] v);
    return (v != '0) && ((v & (v - NUM_SPK'(1))) == '0);
  endfunction

endpackage : spk_vote_pkg
`default_nettype wire

// File: rtl/spk_argmax4.sv
`default_nettype none
// ============================================================================
// Module      : spk_argmax4
// Description : Combinational arg-max over four vote counts. It returns the
//               index and value of the maximum count. It also flags a tie
//               when more than one count equals that maximum.
// Revision    : 1.0 - initial release
// ============================================================================
module spk_argmax4
  import spk_vote_pkg::*;
(
  input  logic [NUM_SPK-1:0][VOTE_W-1:0] i_counts,
  output logic [1:0]                     o_max_idx,
  output logic [VOTE_W-1:0]              o_max_val,
  output logic                           o_tie
);

  logic [2:0] w_n_at_max;

  // Find the first strict maximum, then count how many entries share it.
  always_comb begin
    o_max_val  = i_counts[0];
    o_max_idx  = 2'd0;
    w_n_at_max = 3'd0;
    for (int i = 1; i < NUM_SPK; i++) begin
      if (i_counts[i] > o_max_val) begin
        o_max_val = i_counts[i];
        o_max_idx = 2'(i);
      end
    end
    for (int i = 0; i < NUM_SPK; i++) begin
      if (i_counts[i] == o_max_val) begin
        w_n_at_max = w_n_at_max + 3'd1;
      end
    end
    o_tie = (w_n_at_max > 3'd1);
  end

endmodule : spk_argmax4
`default_nettype wire

// File: rtl/speaker_vote_accum.sv
`default_nettype none
// ============================================================================
// Module      : speaker_vote_accum
// Description : The module collects ROUND_LEN speaker-identification results
//               per round and then declares the speaker with the strictly
//               largest vote count. A speaker is declared only when that count
//               is at least THRESH. Ties and low counts give "unknown".
//               Optional feature: when SPK_VOTE_TIMEOUT_EN is defined, an idle
//               timeout aborts a round that stalls for TIMEOUT_CYC cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module speaker_vote_accum
  import spk_vote_pkg::*;
#(
  parameter int          ROUND_LEN   = 5,
  parameter int          THRESH      = 3,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vote_start,
  input  logic               id_valid,
  input  logic [NUM_SPK-1:0] id_onehot,
  output logic               busy,
  output logic               result_valid,
  output logic [NUM_SPK-1:0] result_onehot,
  output logic               result_known,
  output logic [VOTE_W-1:0]  winner_votes,
  output logic               timed_out
);

  localparam logic [3:0]        C_ROUND_LEN = 4'(ROUND_LEN);
  localparam logic [VOTE_W-1:0] C_THRESH    = VOTE_W'(THRESH);

  vote_state_t                   r_state;
  vote_state_t                   w_next;
  logic [NUM_SPK-1:0][VOTE_W-1:0] r_votes;
  logic [3:0]                    r_sample_cnt;
  logic                          w_open;
  logic                          w_accept;
  logic                          w_last;
  logic                          w_timeout;
  logic [1:0]                    w_max_idx;
  logic [VOTE_W-1:0]             w_max_val;
  logic                          w_tie;
  logic                          w_known;

  assign w_open   = (r_state == ST_IDLE) && vote_start;
  assign w_accept = (r_state == ST_COLLECT) && id_valid;
  assign w_last   = w_accept && (r_sample_cnt == C_ROUND_LEN - 4'd1);

`ifdef SPK_VOTE_TIMEOUT_EN
  logic [31:0] r_idle_cnt;
  logic        r_timed_out;

  // The abort fires one count early. This places result_valid TIMEOUT_CYC
  // cycles after the last accepted id, which matches how the normal 2-cycle
  // decide latency is measured.
  assign w_timeout = (r_state == ST_COLLECT) && !id_valid &&
                     ((r_idle_cnt + 32'd2) >= TIMEOUT_CYC);

  // Idle counter: restarts on round open and on every accepted id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= 32'd0;
    end else if (w_open || w_accept) begin
      r_idle_cnt <= 32'd0;
    end else if (r_state == ST_COLLECT) begin
      r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end

  // Timeout flag: registered with the rest of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timed_out <= 1'b0;
    end else if (r_state == ST_DECIDE) begin
      r_timed_out <= 1'b0;
    end else if (w_timeout) begin
      r_timed_out <= 1'b1;
    end
  end

  assign timed_out = r_timed_out;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_timeout        = 1'b0;
  assign timed_out        = 1'b0;
`endif

  spk_argmax4 u_argmax (
    .i_counts  (r_votes),
    .o_max_idx (w_max_idx),
    .o_max_val (w_max_val),
    .o_tie     (w_tie)
  );

  assign w_known = !w_tie && (w_max_val >= C_THRESH);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Inputs are ignored in every state that does not use them.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (vote_start) w_next = ST_COLLECT;
      ST_COLLECT: begin
        if (w_last)         w_next = ST_DECIDE;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_DECIDE:  w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Sample and vote counters. The sample count stops at ROUND_LEN because the
  // FSM leaves COLLECT on that sample, so no counter can wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_votes      <= '0;
      r_sample_cnt <= 4'd0;
    end else if (w_open) begin
      r_votes      <= '0;
      r_sample_cnt <= 4'd0;
    end else if (w_accept) begin
      r_sample_cnt <= r_sample_cnt + 4'd1;
      if (is_onehot(id_onehot)) begin
        for (int i = 0; i < NUM_SPK; i++) begin
          if (id_onehot[i]) begin
            r_votes[i] <= r_votes[i] + VOTE_W'(1);
          end
        end
      end
    end
  end

  // Result registers. They are held until the next decision or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_onehot <= SPK_UNKNOWN;
      result_known  <= 1'b0;
      winner_votes  <= '0;
    end else if (r_state == ST_DECIDE) begin
      result_onehot <= w_known ? (NUM_SPK'(1) << w_max_idx) : SPK_UNKNOWN;
      result_known  <= w_known;
      winner_votes  <= w_known ? w_max_val : '0;
    end else if (w_timeout) begin
      result_onehot <= SPK_UNKNOWN;
      result_known  <= 1'b0;
      winner_votes  <= '0;
    end
  end

  assign busy         = (r_state == ST_COLLECT) || (r_state == ST_DECIDE);
  assign result_valid = (r_state == ST_DONE);

endmodule : speaker_vote_accum
`default_nettype wire

// File: tb/tb_speaker_vote_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_speaker_vote_accum
// Description : Directed self-checking bench for speaker_vote_accum. It uses
//               a queue scoreboard of expected round results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speaker_vote_accum;

  typedef struct packed {
    logic [3:0] onehot;
    logic       known;
    logic [3:0] votes;
    logic       tout;
  } exp_t;

  exp_t sb[$];
  int   errors  = 0;
  int   checks  = 0;
  int   rv_seen = 0;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       vote_start = 1'b0;
  logic       id_valid   = 1'b0;
  logic [3:0] id_onehot  = 4'b0;
  logic       busy;
  logic       result_valid;
  logic [3:0] result_onehot;
  logic       result_known;
  logic [3:0] winner_votes;
  logic       timed_out;

  speaker_vote_accum #(
    .ROUND_LEN   (5),
    .THRESH      (3),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vote_start    (vote_start),
    .id_valid      (id_valid),
    .id_onehot     (id_onehot),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_onehot (result_onehot),
    .result_known  (result_known),
    .winner_votes  (winner_votes),
    .timed_out     (timed_out)
  );

  always #5 clk = ~clk;

  // Count every result_valid cycle so that unexpected pulses can be caught.
  always @(negedge clk) if (result_valid) rv_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] oh, input logic kn, input logic [3:0] vv, input logic to);
    exp_t e;
    e.onehot = oh; e.known = kn; e.votes = vv; e.tout = to;
    sb.push_back(e);
  endtask

  task automatic start_round();
    @(negedge clk); vote_start = 1'b1;
    @(negedge clk); vote_start = 1'b0;
  endtask

  task automatic pulse_id(input logic [3:0] v);
    @(negedge clk); id_valid = 1'b1; id_onehot = v;
    @(negedge clk); id_valid = 1'b0; id_onehot = 4'b0;
  endtask

  // Ids are packed first-at-top: ids[4] is driven first.
  task automatic drive_ids(input logic [4:0][3:0] ids);
    for (int i = 4; i >= 0; i--) pulse_id(ids[i]);
  endtask

  // The call returns at the negedge just after the final accepting edge.
  // Negedge i after that point lies in the cycle seen by edge i+1, so a
  // result at i=1 means a latency of two edges.
  task automatic await_result(input string tag, input int exp_lat, input int bound);
    int   lat;
    exp_t e;
    lat = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = i + 1;
        break;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    e = sb.pop_front();
    if (lat != 0) begin
      chk({tag, " result_onehot"}, result_onehot, e.onehot);
      chk({tag, " result_known"},  result_known,  e.known);
      chk({tag, " winner_votes"},  winner_votes,  e.votes);
      chk({tag, " timed_out"},     timed_out,     e.tout);
    end
    @(negedge clk);
    chk({tag, " pulse_end"}, result_valid, 1'b0);
    chk({tag, " busy_end"},  busy,         1'b0);
  endtask

  initial begin
    int base;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy",          busy,          1'b0);
    chk("rst result_valid",  result_valid,  1'b0);
    chk("rst result_onehot", result_onehot, 4'b0);
    chk("rst result_known",  result_known,  1'b0);
    chk("rst winner_votes",  winner_votes,  4'd0);
    chk("rst timed_out",     timed_out,     1'b0);
    rst_n = 1'b1;

    // Clear winner with exactly THRESH votes
    push_exp(4'b0001, 1'b1, 4'd3, 1'b0);
    start_round();
    chk("basic busy", busy, 1'b1);
    drive_ids({4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0100});
    await_result("basic", 2, 8);
    repeat (4) @(negedge clk);
    chk("hold result_onehot", result_onehot, 4'b0001);
    chk("hold winner_votes",  winner_votes,  4'd3);

    // Tie at the maximum gives unknown
    push_exp(4'b0000, 1'b0, 4'd0, 1'b0);
    start_round();
    drive_ids({4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100});
    await_result("tie", 2, 8);

    // Invalid ids count as samples only; a best count of 2 is below THRESH
    push_exp(4'b0000, 1'b0, 4'd0, 1'b0);
    start_round();
    drive_ids({4'b1000, 4'b0000, 4'b1100, 4'b1000, 4'b0010});
    await_result("invalid", 2, 8);

    // Unanimous round
    push_exp(4'b0100, 1'b1, 4'd5, 1'b0);
    start_round();
    drive_ids({4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100});
    await_result("unanimous", 2, 8);

    // Ids in IDLE and a vote_start during COLLECT are both ignored
    push_exp(4'b0001, 1'b1, 4'd3, 1'b0);
    pulse_id(4'b0010);
    pulse_id(4'b0010);
    start_round();
    pulse_id(4'b0001);
    pulse_id(4'b0001);
    start_round();
    pulse_id(4'b0010);
    pulse_id(4'b0001);
    pulse_id(4'b0100);
    await_result("ignored", 2, 8);

    // vote_start with id_valid in the same IDLE cycle: that id is not counted
    push_exp(4'b0001, 1'b1, 4'd3, 1'b0);
    @(negedge clk); vote_start = 1'b1; id_valid = 1'b1; id_onehot = 4'b0010;
    @(negedge clk); vote_start = 1'b0; id_valid = 1'b0; id_onehot = 4'b0;
    drive_ids({4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001});
    await_result("same_cycle", 2, 8);

    // Reset mid-round discards the round
    start_round();
    pulse_id(4'b0001);
    pulse_id(4'b0001);
    pulse_id(4'b0001);
    base = rv_seen;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst busy",         busy,         1'b0);
    chk("midrst result_valid", result_valid, 1'b0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst no pulse", rv_seen - base, 0);
    push_exp(4'b0001, 1'b1, 4'd3, 1'b0);
    start_round();
    drive_ids({4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0100});
    await_result("after_rst", 2, 8);

`ifdef SPK_VOTE_TIMEOUT_EN
    // Two ids then silence: abort TIMEOUT_CYC cycles after the last id
    push_exp(4'b0000, 1'b0, 4'd0, 1'b1);
    start_round();
    pulse_id(4'b0001);
    pulse_id(4'b0001);
    await_result("timeout", 100, 150);
`endif

    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_speaker_vote_accum
`default_nettype wire
